// File: rtl/cfg_lut_pkg.sv
// cfg_lut_pkg -- shared types and defaults for the configurable LUT.
//   cfg_state_t : fill state of the serial shadow register
//   DEF_K       : default number of select inputs
//   DEF_INIT    : default truth table loaded at reset
package cfg_lut_pkg;

   typedef enum logic [1:0] {
      EMPTY   = 2'd0,
      FILLING = 2'd1,
      FULL    = 2'd2
   } cfg_state_t;

   localparam int          DEF_K    = 4;
   localparam logic [15:0] DEF_INIT = 16'h2828;

endpackage

// File: rtl/lut_read_mux.sv
// lut_read_mux -- K-level tree of 2:1 muxes selecting one table bit.
//   tbl : truth table, bit i is the result for sel == i
//   sel : select, sel[0] picks between adjacent table bits
//   y   : tbl[sel]
module lut_read_mux #(
   parameter int K = 4
) (
   input  logic [(2**K)-1:0] tbl,
   input  logic [K-1:0]      sel,
   output logic              y
);

   localparam int N = 2**K;

   // Level l halves the candidate vector using sel[l]; the last level
   // leaves a single bit.
   for (genvar l = 0; l < K; l++) begin : g_lvl
      localparam int W = N >> (l + 1);
      logic [2*W-1:0] src;
      logic [W-1:0]   y;
      if (l == 0) begin : g_leaf
         assign src = tbl;
      end else begin : g_node
         assign src = g_lvl[l-1].y;
      end
      for (genvar j = 0; j < W; j++) begin : g_mux
         assign y[j] = sel[l] ? src[2*j+1] : src[2*j];
      end
   end

   assign y = g_lvl[K-1].y[0];

endmodule

// File: rtl/cfg_lut.sv
// cfg_lut -- K-input LUT with serially loaded, double-buffered truth table.
//   clk, rst    : clock, synchronous active-high reset
//   in          : LUT select
//   ce          : output flop enable
//   cfg_en      : shift cfg_din into the shadow register
//   cfg_din     : serial config data, table MSB first
//   cfg_commit  : copy a full shadow register into the active table
//   cfg_dout    : registered shadow MSB (daisy chain)
//   cfg_ack     : one-cycle pulse, commit accepted
//   cfg_err     : one-cycle pulse, commit rejected
//   o_comb      : combinational table[in]
//   o           : registered (REG_OUT=1) or combinational (REG_OUT=0) output
module cfg_lut
   import cfg_lut_pkg::*;
#(
   parameter int               K       = DEF_K,
   parameter logic [(2**K)-1:0] INIT   = DEF_INIT,
   parameter bit               REG_OUT = 1'b0
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [K-1:0] in,
   input  logic         ce,
   input  logic         cfg_en,
   input  logic         cfg_din,
   input  logic         cfg_commit,
   output logic         cfg_dout,
   output logic         cfg_ack,
   output logic         cfg_err,
   output logic         o_comb,
   output logic         o
);

   localparam int N  = 2**K;
   localparam int CW = K + 1;

   cfg_state_t     state, state_nx;
   logic [N-1:0]   tbl, tbl_nx;
   logic [N-1:0]   sh, sh_nx;
   logic [CW-1:0]  cnt, cnt_nx;
   logic           dout_nx;
   logic           commit_ok, commit_bad;
   logic           q;

   // Next-state logic. A shift always wins over a simultaneous commit,
   // which is then reported as rejected.
   always_comb begin
      sh_nx      = sh;
      cnt_nx     = cnt;
      tbl_nx     = tbl;
      dout_nx    = cfg_dout;
      commit_ok  = 1'b0;
      commit_bad = 1'b0;
      if (cfg_en) begin
         sh_nx   = {sh[N-2:0], cfg_din};
         dout_nx = sh[N-1];
         if (cnt != CW'(N))
            cnt_nx = cnt + 1'b1;
      end
      if (cfg_commit) begin
         if (!cfg_en && state == FULL) begin
            tbl_nx    = sh;       // shadow kept: a re-commit needs N new shifts
            cnt_nx    = '0;
            commit_ok = 1'b1;
         end else begin
            commit_bad = 1'b1;
         end
      end
   end

   always_comb begin
      state_nx = FILLING;
      if (cnt_nx == '0)
         state_nx = EMPTY;
      else if (cnt_nx == CW'(N))
         state_nx = FULL;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= EMPTY;
         tbl      <= INIT;
         sh       <= '0;
         cnt      <= '0;
         cfg_dout <= 1'b0;
         cfg_ack  <= 1'b0;
         cfg_err  <= 1'b0;
         q        <= 1'b0;
      end else begin
         state    <= state_nx;
         tbl      <= tbl_nx;
         sh       <= sh_nx;
         cnt      <= cnt_nx;
         cfg_dout <= dout_nx;
         cfg_ack  <= commit_ok;
         cfg_err  <= commit_bad;
         if (ce)
            q <= o_comb;
      end
   end

   lut_read_mux #(.K(K)) u_mux (
      .tbl (tbl),
      .sel (in),
      .y   (o_comb)
   );

   assign o = REG_OUT ? q : o_comb;

endmodule

// File: tb/tb_cfg_lut.sv
module tb_cfg_lut;

   logic       clk = 1'b0;
   logic       rst, ce, cfg_en, cfg_din, cfg_commit;
   logic [3:0] in;
   logic       dout0, ack0, err0, oc0, o0;
   logic       dout1, ack1, err1, oc1, o1;

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic [3:0] in;
      logic       exp;
   } vec_t;

   vec_t vec_init [16];

   always #5 clk = ~clk;

   cfg_lut #(.K(4), .INIT(16'h2828), .REG_OUT(1'b0)) u0 (
      .clk(clk), .rst(rst), .in(in), .ce(ce), .cfg_en(cfg_en),
      .cfg_din(cfg_din), .cfg_commit(cfg_commit), .cfg_dout(dout0),
      .cfg_ack(ack0), .cfg_err(err0), .o_comb(oc0), .o(o0)
   );

   cfg_lut #(.K(4), .INIT(16'h2828), .REG_OUT(1'b1)) u1 (
      .clk(clk), .rst(rst), .in(in), .ce(ce), .cfg_en(cfg_en),
      .cfg_din(cfg_din), .cfg_commit(cfg_commit), .cfg_dout(dout1),
      .cfg_ack(ack1), .cfg_err(err1), .o_comb(oc1), .o(o1)
   );

   task automatic chk(input string nm, input logic act, input logic exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %b want %b", nm, act, exp);
      end
   endtask

   // Inputs change 1 time unit after the edge; outputs are sampled there too.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic shift_n(input int n, input logic b);
      cfg_en  = 1'b1;
      cfg_din = b;
      repeat (n) tick();
      cfg_en  = 1'b0;
   endtask

   task automatic commit();
      cfg_commit = 1'b1;
      tick();
      cfg_commit = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   task automatic probe(input string nm, input logic [3:0] sel, input logic exp);
      in = sel;
      #1;
      chk(nm, oc0, exp);
   endtask

   initial begin
      for (int i = 0; i < 16; i++) begin
         vec_init[i].in  = 4'(i);
         vec_init[i].exp = (i == 3 || i == 5 || i == 11 || i == 13);
      end

      rst = 1'b0; ce = 1'b0; cfg_en = 1'b0; cfg_din = 1'b0; cfg_commit = 1'b0;
      in = 4'd0;

      // Reset state and INIT sweep
      do_reset();
      chk("rst_ack", ack0, 1'b0);
      chk("rst_err", err0, 1'b0);
      chk("rst_dout", dout0, 1'b0);
      chk("rst_q", o1, 1'b0);
      for (int i = 0; i < 16; i++) begin
         in = vec_init[i].in;
         #1;
         chk($sformatf("init_ocomb[%0d]", i), oc0, vec_init[i].exp);
         chk($sformatf("init_o[%0d]", i), o0, vec_init[i].exp);
      end

      // 16 ones then commit: accepted, table all ones
      shift_n(16, 1'b1);
      commit();
      chk("ones_ack", ack0, 1'b1);
      chk("ones_err", err0, 1'b0);
      tick();
      chk("ones_ack_pulse", ack0, 1'b0);
      for (int i = 0; i < 16; i++)
         probe($sformatf("ones_ocomb[%0d]", i), 4'(i), 1'b1);

      // 15 shifts then commit: rejected, INIT kept
      do_reset();
      shift_n(15, 1'b1);
      commit();
      chk("short_err", err0, 1'b1);
      chk("short_ack", ack0, 1'b0);
      probe("short_in3", 4'd3, 1'b1);
      probe("short_in0", 4'd0, 1'b0);

      // 20 shifts 1,0,0,...: the leading 1 leaves via cfg_dout on shift 17
      do_reset();
      for (int i = 0; i < 20; i++) begin
         cfg_en  = 1'b1;
         cfg_din = (i == 0);
         tick();
         chk($sformatf("dout_shift%0d", i + 1), dout0, (i == 16));
      end
      cfg_en = 1'b0;
      commit();
      chk("over_ack", ack0, 1'b1);
      probe("over_in3", 4'd3, 1'b0);
      probe("over_in5", 4'd5, 1'b0);
      probe("over_in13", 4'd13, 1'b0);

      // Registered output holds while ce is low
      do_reset();
      in = 4'd3;
      tick();
      chk("q_before_ce", o1, 1'b0);
      ce = 1'b1;
      tick();
      chk("q_load1", o1, 1'b1);
      ce = 1'b0;
      in = 4'd0;
      #1;
      chk("q_ocomb0", oc1, 1'b0);
      chk("q_hold_now", o1, 1'b1);
      tick();
      chk("q_hold_edge", o1, 1'b1);
      ce = 1'b1;
      tick();
      chk("q_load0", o1, 1'b0);
      ce = 1'b0;

      // Reset overrides a commit in FULL
      do_reset();
      shift_n(16, 1'b1);
      rst = 1'b1; cfg_commit = 1'b1; ce = 1'b1;
      tick();
      rst = 1'b0; cfg_commit = 1'b0; ce = 1'b0;
      chk("rstov_ack", ack0, 1'b0);
      chk("rstov_q", o1, 1'b0);
      probe("rstov_in0", 4'd0, 1'b0);

      // Reset after 8 shifts discards them
      shift_n(8, 1'b1);
      rst = 1'b1; cfg_en = 1'b1;
      tick();
      rst = 1'b0; cfg_en = 1'b0;
      commit();
      chk("partial_err", err0, 1'b1);
      shift_n(8, 1'b1);
      commit();
      chk("partial8_err", err0, 1'b1);
      chk("partial8_ack", ack0, 1'b0);
      probe("partial_in3", 4'd3, 1'b1);
      probe("partial_in0", 4'd0, 1'b0);

      // Shift and commit together in FULL: rejected, then a plain commit works
      shift_n(8, 1'b1);
      cfg_en = 1'b1; cfg_din = 1'b1; cfg_commit = 1'b1;
      tick();
      cfg_en = 1'b0; cfg_commit = 1'b0;
      chk("both_err", err0, 1'b1);
      chk("both_ack", ack0, 1'b0);
      probe("both_in0", 4'd0, 1'b0);
      commit();
      chk("after_ack", ack0, 1'b1);
      probe("after_in0", 4'd0, 1'b1);
      commit();
      chk("recommit_err", err0, 1'b1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
